// File: rtl/spi_slave_rx_tx_if.sv
// SPI slave bus bundle: serial pins toward the master plus the parallel RAM-side handshake.
// The slave modport is the view taken by spi_slave_rx_tx.
interface spi_slave_rx_tx_if #(
    parameter int ADDR_SIZE = 8
);
    logic                   MOSI;
    logic                   SS_n;
    logic                   MISO;
    logic [ADDR_SIZE+1:0]   rx_data;
    logic                   rx_valid;
    logic [ADDR_SIZE-1:0]   tx_data;
    logic                   tx_valid;

    modport slave (
        input  MOSI,
        input  SS_n,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    modport master (
        output MOSI,
        output SS_n,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_slave_rx_tx.sv
// SPI slave front end: deserialises command frames for the RAM and serialises read data on MISO.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse when SS_n rises mid-frame or mid-readback.
module spi_slave_rx_tx #(
    parameter int ADDR_SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_rx_tx_if.slave  bus
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int Frame = ADDR_SIZE + 2;
    localparam int CntW  = $clog2(Frame + 1);
    localparam int TxW   = $clog2(ADDR_SIZE + 1);

    localparam logic [CntW-1:0] LastBit = CntW'(Frame - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Frame);
    localparam logic [TxW-1:0]  TxRest  = TxW'(ADDR_SIZE - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StChkCmd   = 3'd1;
    localparam logic [2:0] StWrite    = 3'd2;
    localparam logic [2:0] StReadAdd  = 3'd3;
    localparam logic [2:0] StReadData = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [Frame-2:0]     shift_q, shift_d;
    logic [Frame-1:0]     rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rd_addr_flag_q, rd_addr_flag_d;
    logic [ADDR_SIZE-1:0] tx_sr_q, tx_sr_d;
    logic [TxW-1:0]       tx_rem_q, tx_rem_d;
    logic                 tx_cap_q, tx_cap_d;
    logic                 miso_q, miso_d;
    logic                 frame_done;
`ifdef SPI_FRAME_ERR_EN
    logic                 frame_err_q, frame_err_d;
`endif

    // Counter saturates at the full frame length; that is the "frame received" marker.
    assign frame_done = (bit_cnt_q == FullCnt);

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_flag_d = rd_addr_flag_q;
        tx_sr_d        = tx_sr_q;
        tx_rem_d       = tx_rem_q;
        tx_cap_d       = tx_cap_q;
        miso_d         = 1'b0;
`ifdef SPI_FRAME_ERR_EN
        frame_err_d    = 1'b0;
`endif

        if (state_q == StIdle) begin
            bit_cnt_d = '0;
            tx_cap_d  = 1'b0;
            tx_rem_d  = '0;
            if (!bus.SS_n) begin
                state_d = StChkCmd;
            end
        end else if (bus.SS_n) begin
            // Deselect wins over everything, including the last data bit.
            state_d   = StIdle;
            bit_cnt_d = '0;
            tx_sr_d   = '0;
            tx_rem_d  = '0;
            tx_cap_d  = 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_d = !frame_done ||
                          ((state_q == StReadData) && (!tx_cap_q || (tx_rem_q != '0)));
`endif
        end else if (state_q == StChkCmd) begin
            shift_d   = {shift_q[Frame-3:0], bus.MOSI};
            bit_cnt_d = CntW'(1);
            if (!bus.MOSI) begin
                state_d = StWrite;
            end else if (!rd_addr_flag_q) begin
                state_d = StReadAdd;
            end else begin
                state_d = StReadData;
            end
        end else begin
            if (!frame_done) begin
                shift_d   = {shift_q[Frame-3:0], bus.MOSI};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LastBit) begin
                    rx_data_d  = {shift_q, bus.MOSI};
                    rx_valid_d = 1'b1;
                    if (state_q == StReadAdd) begin
                        rd_addr_flag_d = 1'b1;
                    end else if (state_q == StReadData) begin
                        rd_addr_flag_d = 1'b0;
                    end
                end
            end

            // Readback: one capture per frame, only once the command has been handed over.
            if (state_q == StReadData) begin
                if (frame_done && !tx_cap_q && bus.tx_valid) begin
                    tx_cap_d = 1'b1;
                    miso_d   = bus.tx_data[ADDR_SIZE-1];
                    tx_sr_d  = {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
                    tx_rem_d = TxRest;
                end else if (tx_rem_q != '0) begin
                    miso_d   = tx_sr_q[ADDR_SIZE-1];
                    tx_sr_d  = {tx_sr_q[ADDR_SIZE-2:0], 1'b0};
                    tx_rem_d = tx_rem_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_flag_q <= 1'b0;
            tx_sr_q        <= '0;
            tx_rem_q       <= '0;
            tx_cap_q       <= 1'b0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_flag_q <= rd_addr_flag_d;
            tx_sr_q        <= tx_sr_d;
            tx_rem_q       <= tx_rem_d;
            tx_cap_q       <= tx_cap_d;
            miso_q         <= miso_d;
        end
    end

`ifdef SPI_FRAME_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`endif

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: frames and read data are queued as expectations when
// driven and popped when the DUT presents rx_valid or shifts MISO.
module tb_spi_slave_rx_tx;

    localparam logic [2:0] Idle = 3'd0;

    logic clk;
    logic rst;
`ifdef SPI_FRAME_ERR_EN
    logic frame_err;
`endif

    spi_slave_rx_tx_if #(.ADDR_SIZE(8)) bus ();

    spi_slave_rx_tx #(.ADDR_SIZE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [9:0] exp_rx[$];
    logic       exp_miso[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Select, then drive the first n bits MSB first; a tx_valid pulse can be injected at bit 3.
    task automatic send_bits(input logic [9:0] f, input int n, input bit spur);
        logic [9:0] fr;
        fr = f;
        bus.SS_n = 1'b0;
        step();
        for (int i = 0; i < n; i++) begin
            bus.MOSI     = fr[9-i];
            bus.tx_valid = spur && (i == 3);
            bus.tx_data  = 8'hFF;
            step();
            bus.tx_valid = 1'b0;
            chk("miso_idle_rx", {31'd0, bus.MISO}, 32'd0);
            if (i < 9) chk("no_early_valid", {31'd0, bus.rx_valid}, 32'd0);
        end
    endtask

    task automatic send_frame(input logic [9:0] f, input bit spur);
        logic [9:0] e;
        exp_rx.push_back(f);
        send_bits(f, 10, spur);
        chk("rx_valid_hi", {31'd0, bus.rx_valid}, 32'd1);
        if (bus.rx_valid && exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            chk("rx_data", {22'd0, bus.rx_data}, {22'd0, e});
        end
        step();
        chk("rx_valid_one_cycle", {31'd0, bus.rx_valid}, 32'd0);
    endtask

    task automatic end_frame();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        step();
        chk("idle_after_ss", {29'd0, dut.state_q}, {29'd0, Idle});
    endtask

    initial begin
        logic [7:0] rd;
        logic       b;
        rst          = 1'b1;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        step();
        step();
        chk("rst_miso", {31'd0, bus.MISO}, 32'd0);
        chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_rx_data", {22'd0, bus.rx_data}, 32'd0);
        chk("rst_state", {29'd0, dut.state_q}, {29'd0, Idle});
        chk("rst_flag", {31'd0, dut.rd_addr_flag_q}, 32'd0);
        rst = 1'b0;
        step();

        // Write address
        send_frame(10'b00_1010_0101, 1'b0);
        chk("wr_addr_flag", {31'd0, dut.rd_addr_flag_q}, 32'd0);
        end_frame();

        // Reset after 4 bits of a frame
        send_bits(10'b01_1111_1111, 4, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_miso", {31'd0, bus.MISO}, 32'd0);
        chk("midrst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("midrst_rx_data", {22'd0, bus.rx_data}, 32'd0);
        chk("midrst_state", {29'd0, dut.state_q}, {29'd0, Idle});
        rst = 1'b0;
        bus.SS_n = 1'b1;
        step();

        // Write data, then read address
        send_frame(10'b01_0011_1100, 1'b0);
        end_frame();
        send_frame(10'b10_1010_0101, 1'b0);
        chk("rd_addr_flag_set", {31'd0, dut.rd_addr_flag_q}, 32'd1);
        end_frame();

        // Abort after 5 bits: no rx_valid, flag held
        send_bits(10'b00_1111_0000, 5, 1'b0);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        step();
        chk("abort_no_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("abort_state", {29'd0, dut.state_q}, {29'd0, Idle});
        chk("abort_flag_kept", {31'd0, dut.rd_addr_flag_q}, 32'd1);
`ifdef SPI_FRAME_ERR_EN
        chk("abort_frame_err", {31'd0, frame_err}, 32'd1);
`endif
        step();
        chk("abort_no_valid_late", {31'd0, bus.rx_valid}, 32'd0);
`ifdef SPI_FRAME_ERR_EN
        chk("abort_frame_err_pulse", {31'd0, frame_err}, 32'd0);
`endif

        // Read data with RAM answering one cycle after rx_valid
        send_frame(10'b11_0000_0000, 1'b0);
        chk("rd_data_flag_clr", {31'd0, dut.rd_addr_flag_q}, 32'd0);
        rd = 8'hC3;
        for (int i = 7; i >= 0; i--) exp_miso.push_back(rd[i]);
        bus.tx_valid = 1'b1;
        bus.tx_data  = rd;
        step();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (exp_miso.size() > 0) begin
                b = exp_miso.pop_front();
                chk($sformatf("miso_bit%0d", i), {31'd0, bus.MISO}, {31'd0, b});
            end
            step();
        end
        chk("miso_tail_zero", {31'd0, bus.MISO}, 32'd0);
        chk("readback_drained", exp_miso.size(), 32'd0);
        end_frame();
`ifdef SPI_FRAME_ERR_EN
        chk("no_err_full_read", {31'd0, frame_err}, 32'd0);
`endif

        // SS_n rises on the edge carrying the last bit: aborted
        send_bits(10'b00_0101_0101, 9, 1'b0);
        bus.MOSI = 1'b1;
        bus.SS_n = 1'b1;
        step();
        chk("lastbit_abort_no_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("lastbit_abort_state", {29'd0, dut.state_q}, {29'd0, Idle});
`ifdef SPI_FRAME_ERR_EN
        chk("lastbit_abort_err", {31'd0, frame_err}, 32'd1);
`endif
        step();

        // Spurious tx_valid during a write frame is ignored
        send_frame(10'b00_0110_1001, 1'b1);
        chk("spur_miso", {31'd0, bus.MISO}, 32'd0);
        chk("spur_flag", {31'd0, dut.rd_addr_flag_q}, 32'd0);
        end_frame();
        chk("rx_queue_drained", exp_rx.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx_tx.md
Name: spi_slave_rx_tx

Overview:
- Serial front end that sits directly upstream of the single-port RAM.
- Deserialises MOSI frames of ADDR_SIZE+2 bits into a parallel command word and hands it to the RAM with a one-cycle rx_valid strobe.
- On read-data commands, captures the RAM's returned byte (tx_valid/tx_data) and shifts it out on MISO.
- Runs entirely on the SPI clock as the single clock domain.

Parameters:
- ADDR_SIZE, 8, width of address/data payload; frame width is ADDR_SIZE+2 (2 opcode bits + payload).

Ports:
- clk  input  1  SPI serial clock; all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- MOSI  input  1  serial data in, MSB first.
- SS_n  input  1  active-low slave select; frame boundary.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  ADDR_SIZE+2  assembled frame to RAM; [ADDR_SIZE+1:ADDR_SIZE] = opcode, [ADDR_SIZE-1:0] = payload.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  ADDR_SIZE  read data from RAM.
- tx_valid  input  1  tx_data valid (one-cycle pulse from RAM).

Behaviour:
- Reset (async, rst=1):
  - MISO=0, rx_data=0, rx_valid=0.
  - state=IDLE; bit counter=0; rd_addr_flag=0; tx shift register=0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - IDLE: SS_n=0 sampled -> CHK_CMD; else stay.
  - CHK_CMD: sample MOSI as frame bit [ADDR_SIZE+1]. MOSI=0 -> WRITE. MOSI=1 and rd_addr_flag=0 -> READ_ADD. MOSI=1 and rd_addr_flag=1 -> READ_DATA.
  - WRITE/READ_ADD/READ_DATA: shift in the remaining ADDR_SIZE+1 bits, one per edge, MSB first.
- Frame completion:
  - On the edge sampling the last bit, rx_data <= full frame and rx_valid <= 1. rx_valid deasserts the next cycle.
  - Frame bits are forwarded verbatim; the opcode bit [ADDR_SIZE] is not re-checked.
  - Frame of 10 bits (ADDR_SIZE=8): SS_n low sampled at edge 0, bits at edges 1..10, rx_valid high in the cycle after edge 10.
- rd_addr_flag:
  - Set on frame completion in READ_ADD.
  - Cleared on frame completion in READ_DATA.
  - Unchanged on abort.
- After frame completion, the FSM holds in its state and ignores MOSI until SS_n=1.
- READ_DATA readback:
  - After rx_valid, the first edge with tx_valid=1 loads tx_data.
  - On that edge MISO <= tx_data[ADDR_SIZE-1]; the following ADDR_SIZE-1 edges shift out the remaining bits.
  - MISO returns to 0 after the last bit.
  - tx_valid is ignored outside READ_DATA, before rx_valid, and after one capture per frame.
- SS_n=1 sampled in any non-IDLE state:
  - Next state IDLE; bit counter cleared; MISO <= 0; any in-progress shift-out is abandoned.
  - No rx_valid if the frame was incomplete.
- SS_n=1 on the same edge as the last data bit: the frame is aborted (SS_n has priority) and no rx_valid is issued.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
- MISO is 0 whenever not shifting read data.

Optional Feature:
- Macro: SPI_FRAME_ERR_EN.
- Defined:
  - Adds output port frame_err (1 bit, reset 0).
  - frame_err pulses high for exactly one cycle after SS_n rises with a partially received frame (CHK_CMD through the second-to-last bit).
  - Also pulses when SS_n rises in READ_DATA before the readback shift-out completes.
- Undefined: port and logic absent; aborts are silent.

Test Plan:
- Reset: assert rst mid-frame (after 4 bits) -> MISO=0, rx_valid=0, rx_data=0 immediately; the next full frame is received correctly.
- Write address: SS_n low, MOSI 00_1010_0101 -> rx_data=10'h0A5, rx_valid high for exactly 1 cycle after the 10th bit; rd_addr_flag stays 0.
- Write data then read address: frames 01_0011_1100 and 10_1010_0101 -> rx_data=10'h13C, then 10'h2A5; rd_addr_flag=1 after the second frame.
- Read data: with rd_addr_flag=1, send 11_0000_0000; model RAM returns tx_valid with tx_data=8'hC3 one cycle after rx_valid -> MISO serialises 1,1,0,0,0,0,1,1 on consecutive edges, then 0; rd_addr_flag=0.
- Abort: SS_n rises after 5 bits of 00_1111_0000 -> no rx_valid, FSM in IDLE next cycle, rd_addr_flag unchanged; frame_err=1 for one cycle if SPI_FRAME_ERR_EN.
- Spurious tx_valid: pulse tx_valid with tx_data=8'hFF during a WRITE frame -> MISO stays 0; no state change.
